// File: rtl/sorting_module_3_inputs.sv
// Three-input unsigned descending sorter: high/med/low, registered, one triple per clock.
// Define SORT3_PIPELINE_EN to split compare and select into two stages (latency 2 instead of 1).
module sorting_module_3_inputs #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_2,
  input  logic [DATA_WIDTH-1:0] in_3,
  output logic [DATA_WIDTH-1:0] high,
  output logic [DATA_WIDTH-1:0] med,
  output logic [DATA_WIDTH-1:0] low
);

  logic [DATA_WIDTH-1:0] op_a, op_b, op_c;
  logic                  f_ab, f_ac, f_bc;

`ifdef SORT3_PIPELINE_EN
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                  ab_q, ab_d, ac_q, ac_d, bc_q, bc_d;

  always_comb begin
    a_d  = in_1;
    b_d  = in_2;
    c_d  = in_3;
    ab_d = (in_1 > in_2);
    ac_d = (in_1 > in_3);
    bc_d = (in_2 > in_3);
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      ab_q <= 1'b0;
      ac_q <= 1'b0;
      bc_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      ab_q <= ab_d;
      ac_q <= ac_d;
      bc_q <= bc_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
  assign op_c = c_q;
  assign f_ab = ab_q;
  assign f_ac = ac_q;
  assign f_bc = bc_q;
`else
  assign op_a = in_1;
  assign op_b = in_2;
  assign op_c = in_3;
  assign f_ab = (in_1 > in_2);
  assign f_ac = (in_1 > in_3);
  assign f_bc = (in_2 > in_3);
`endif

  logic [DATA_WIDTH-1:0] high_q, high_d, med_q, med_d, low_q, low_d;

  // Every branch routes each operand to exactly one output, so ties can never
  // duplicate or drop an operand.
  always_comb begin
    high_d = op_a;
    med_d  = op_b;
    low_d  = op_c;
    if (f_ab) begin
      if (f_bc) begin
        high_d = op_a; med_d = op_b; low_d = op_c;
      end else if (f_ac) begin
        high_d = op_a; med_d = op_c; low_d = op_b;
      end else begin
        high_d = op_c; med_d = op_a; low_d = op_b;
      end
    end else begin
      if (!f_bc) begin
        high_d = op_c; med_d = op_b; low_d = op_a;
      end else if (f_ac) begin
        high_d = op_b; med_d = op_a; low_d = op_c;
      end else begin
        high_d = op_b; med_d = op_c; low_d = op_a;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      high_q <= '0;
      med_q  <= '0;
      low_q  <= '0;
    end else begin
      high_q <= high_d;
      med_q  <= med_d;
      low_q  <= low_d;
    end
  end

  assign high = high_q;
  assign med  = med_q;
  assign low  = low_q;

endmodule

// File: tb/tb_sorting_module_3_inputs.sv
// Self-checking bench for sorting_module_3_inputs: directed table, reset corner cases, random stream.
module tb_sorting_module_3_inputs;
  localparam int W = 8;
`ifdef SORT3_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         i_clk = 1'b0;
  logic         i_aresetn = 1'b0;
  logic [W-1:0] in_1 = '0, in_2 = '0, in_3 = '0;
  logic [W-1:0] high, med, low;

  always #5 i_clk = ~i_clk;

  sorting_module_3_inputs #(.DATA_WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_aresetn(i_aresetn),
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .high     (high),
    .med      (med),
    .low      (low)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic [W-1:0] h, m, l;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  // Expected-output delay line, one entry per register stage.
  logic [W-1:0] ph[LAT], pm[LAT], pl[LAT];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] eh, em, el);
    n_vec++;
    if ({high, med, low} !== {eh, em, el}) begin
      n_err++;
      $display("FAIL %s: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
               name, high, med, low, eh, em, el);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      ph[i] = '0; pm[i] = '0; pl[i] = '0;
    end
  endtask

  task automatic step(input string name, input logic [W-1:0] a, b, c, eh, em, el);
    @(negedge i_clk);
    in_1 = a; in_2 = b; in_3 = c;
    @(posedge i_clk);
    for (int i = LAT - 1; i > 0; i--) begin
      ph[i] = ph[i-1]; pm[i] = pm[i-1]; pl[i] = pl[i-1];
    end
    ph[0] = eh; pm[0] = em; pl[0] = el;
    #1;
    check(name, ph[LAT-1], pm[LAT-1], pl[LAT-1]);
    $display("%s in=(%0d,%0d,%0d) out=(%0d,%0d,%0d)", name, a, b, c, high, med, low);
  endtask

  logic [W-1:0] x, y, z, t;

  initial begin
    vecs[0]  = '{a: 8'd10,  b: 8'd5,   c: 8'd7,   h: 8'd10,  m: 8'd7,   l: 8'd5};
    vecs[1]  = '{a: 8'd100, b: 8'd255, c: 8'd150, h: 8'd255, m: 8'd150, l: 8'd100};
    vecs[2]  = '{a: 8'd180, b: 8'd20,  c: 8'd182, h: 8'd182, m: 8'd180, l: 8'd20};
    vecs[3]  = '{a: 8'd180, b: 8'd180, c: 8'd180, h: 8'd180, m: 8'd180, l: 8'd180};
    vecs[4]  = '{a: 8'd5,   b: 8'd5,   c: 8'd9,   h: 8'd9,   m: 8'd5,   l: 8'd5};
    vecs[5]  = '{a: 8'd180, b: 8'd190, c: 8'd3,   h: 8'd190, m: 8'd180, l: 8'd3};
    vecs[6]  = '{a: 8'd0,   b: 8'd255, c: 8'd0,   h: 8'd255, m: 8'd0,   l: 8'd0};
    vecs[7]  = '{a: 8'd7,   b: 8'd7,   c: 8'd2,   h: 8'd7,   m: 8'd7,   l: 8'd2};
    vecs[8]  = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   h: 8'd3,   m: 8'd2,   l: 8'd1};
    vecs[9]  = '{a: 8'd3,   b: 8'd1,   c: 8'd2,   h: 8'd3,   m: 8'd2,   l: 8'd1};
    vecs[10] = '{a: 8'd2,   b: 8'd3,   c: 8'd1,   h: 8'd3,   m: 8'd2,   l: 8'd1};

    clear_pipe();

    // Reset held across edges with zero inputs.
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_state", '0, '0, '0);
    @(negedge i_clk);
    i_aresetn = 1'b1;

    // Directed table, streamed back-to-back.
    for (int i = 0; i < NVEC; i++)
      step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
           vecs[i].h, vecs[i].m, vecs[i].l);
    for (int i = 0; i < LAT; i++)
      step("drain", '0, '0, '0, '0, '0, '0);

    // Mid-stream asynchronous reset between edges.
    step("pre_rst0", 8'd40, 8'd60, 8'd50, 8'd60, 8'd50, 8'd40);
    step("pre_rst1", 8'd9, 8'd8, 8'd200, 8'd200, 8'd9, 8'd8);
    #2;
    i_aresetn = 1'b0;
    #1;
    check("async_reset", '0, '0, '0);
    clear_pipe();
    in_1 = 8'd77; in_2 = 8'd66; in_3 = 8'd88;
    @(posedge i_clk);
    #1;
    check("reset_hold_edge", '0, '0, '0);
    #2;
    i_aresetn = 1'b1;
    step("post_rst0", 8'd10, 8'd5, 8'd7, 8'd10, 8'd7, 8'd5);
    step("post_rst1", 8'd250, 8'd251, 8'd249, 8'd251, 8'd250, 8'd249);

    // Random stream against a swap-based reference sort; small ranges force ties.
    for (int n = 0; n < 10000; n++) begin
      if (n % 2 == 0) begin
        x = W'($urandom_range(0, 3)); y = W'($urandom_range(0, 3)); z = W'($urandom_range(0, 3));
      end else begin
        x = W'($urandom_range(0, 255)); y = W'($urandom_range(0, 255)); z = W'($urandom_range(0, 255));
      end
      in_1 = x;
      begin
        logic [W-1:0] a0, b0, c0;
        a0 = x; b0 = y; c0 = z;
        if (x < y) begin t = x; x = y; y = t; end
        if (y < z) begin t = y; y = z; z = t; end
        if (x < y) begin t = x; x = y; y = t; end
        step($sformatf("rand%0d", n), a0, b0, c0, x, y, z);
      end
      n_vec++;
      if (!(high >= med && med >= low)) begin
        n_err++;
        $display("FAIL order%0d: got (%0d,%0d,%0d) expected high>=med>=low", n, high, med, low);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
